mem_responder: RTL

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_pkg.sv | 11 +
 rtl/mem_word_array.sv | 18 +
 rtl/mem_responder.sv | 79 +++++++
 3 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared command layout and FSM state encoding for the memory responder.
// Command packing is {write_en, word_addr[31:0], wdata[31:0]}.
package mem_pkg;
    localparam int CMD_W   = 65;
    localparam int WE_BIT  = 64;
    localparam int ADDR_HI = 63;
    localparam int ADDR_LO = 32;
    localparam int DATA_HI = 31;
    localparam int DATA_LO = 0;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
endpackage

// File: rtl/mem_word_array.sv
// mem_word_array: single-port DEPTH_WORDS x 32 storage, synchronous write, combinational read.
// Ports: clk, we (write strobe), addr (word index), wdata (write data), rdata (read data at addr).
module mem_word_array #(
    parameter int DEPTH_WORDS = 512,
    parameter int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [31:0] mem [DEPTH_WORDS];
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end
    assign rdata = mem[addr];
endmodule

// File: rtl/mem_responder.sv
// mem_responder: request/response memory model with fixed wait latency and range checking.
// Ports: clk, rst (sync, active-high); req_valid/req_ready/req_cmd request channel;
// resp_valid/resp_ready/resp_data/resp_err response channel.
module mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 512,
    parameter int LATENCY     = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [CMD_W-1:0] req_cmd,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_data,
    output logic             resp_err
);
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] DEPTH = 33'(DEPTH_WORDS);
    state_t           state;
    logic [3:0]       cnt;
    logic [CMD_W-1:0] cmd_q;
    logic [CMD_W-1:0] cur;
    logic             fire;
    logic             in_range;
    logic             mem_we;
    logic [31:0]      rdata;
    // With zero latency the response is produced on the acceptance edge, so the live command is used.
    always_comb begin
        cur      = (state == IDLE) ? req_cmd : cmd_q;
        fire     = (state == IDLE && req_valid && LATENCY == 0) || (state == WAIT && cnt == 4'd1);
        in_range = {1'b0, cur[ADDR_HI:ADDR_LO]} < DEPTH;
        mem_we   = fire && cur[WE_BIT] && in_range && !rst;
    end
    assign req_ready = (state == IDLE) && !rst;
    mem_word_array #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .addr  (cur[ADDR_LO +: AW]),
        .wdata (cur[DATA_HI:DATA_LO]),
        .rdata (rdata)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            cmd_q      <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    cmd_q <= req_cmd;
                    cnt   <= 4'(LATENCY);
                    state <= (LATENCY == 0) ? RESP : WAIT;
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) state <= RESP;
                end
                RESP: if (resp_ready) begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    resp_data  <= '0;
                    resp_err   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
            if (fire) begin
                resp_valid <= 1'b1;
                resp_err   <= !in_range;
                resp_data  <= !in_range ? 32'd0 : cur[WE_BIT] ? cur[DATA_HI:DATA_LO] : rdata;
            end
        end
    end
endmodule
